// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI command/address/data register bridge.
package spi_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WRITE,
    READ
  } state_t;

  localparam int              CMD_W_BIT = 7;
  localparam int              ADDR_W    = 7;
  localparam logic [ADDR_W-1:0] ID_ADDR = 7'h7F;
  localparam logic [7:0]      READ_MISS = 8'h00;

endpackage

// File: rtl/spi_reg_bank.sv
// Bank of 8-bit control registers: synchronous write port, combinational read mux with ID/miss values.
// Write visible 1 clk after we; read is 0 clk; no backpressure, out-of-range writes are dropped.
module spi_reg_bank
  import spi_bridge_pkg::*;
#(
  parameter int         NUM_REGS  = 8,
  parameter logic [7:0] ID_VALUE  = 8'hA5,
  parameter logic [7:0] LED_RESET = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [7:0]            wr_data,
  output logic                  wr_hit,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [7:0]            rd_data,
  output logic [8*NUM_REGS-1:0] regs_flat
);

  logic [7:0] regs [NUM_REGS];

  assign wr_hit = (32'(wr_addr) < 32'(NUM_REGS));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == 0) ? LED_RESET : 8'h00;
      end
    end else if (we) begin
      // An address beyond the bank matches no entry, so the write falls away.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_addr == ADDR_W'(i)) regs[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data = READ_MISS;
    if (rd_addr == ID_ADDR) rd_data = ID_VALUE;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = regs[i];
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_flat[8*i +: 8] = regs[i];
    end
  end

endmodule

// File: rtl/spi_register_bridge.sv
// Decodes SPI command/address/data frames into register writes and read-back bytes.
// tx_byte/tx_load and wr_strobe follow rx_valid by 1 clk; no backpressure, ss high aborts a frame.
module spi_register_bridge
  import spi_bridge_pkg::*;
#(
  parameter int         NUM_REGS  = 8,
  parameter logic [7:0] ID_VALUE  = 8'hA5,
  parameter logic [7:0] LED_RESET = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic [7:0]            tx_byte,
  output logic                  tx_load,
  output logic [7:0]            led,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr
);

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   rd_addr;
  logic [7:0]          rd_data;
  logic                wr_hit;
  logic                we;

  assign we = (state == WRITE) && rx_valid && !ss;

  // The command byte carries its own address; later reads look one ahead.
  assign rd_addr = (state == CMD) ? rx_byte[ADDR_W-1:0] : addr + 7'd1;

  spi_reg_bank #(
    .NUM_REGS  (NUM_REGS),
    .ID_VALUE  (ID_VALUE),
    .LED_RESET (LED_RESET)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wr_addr   (addr),
    .wr_data   (rx_byte),
    .wr_hit    (wr_hit),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .regs_flat (regs_flat)
  );

  assign led = regs_flat[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      tx_byte   <= 8'h00;
      tx_load   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
    end else begin
      tx_load   <= 1'b0;
      wr_strobe <= 1'b0;
      if (ss) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= CMD;
          CMD: begin
            tx_byte <= 8'h00;
            if (rx_valid) begin
              addr <= rx_byte[ADDR_W-1:0];
              if (rx_byte[CMD_W_BIT]) begin
                state <= WRITE;
              end else begin
                state   <= READ;
                tx_byte <= rd_data;
                tx_load <= 1'b1;
              end
            end
          end
          WRITE: begin
            tx_byte <= 8'h00;
            if (rx_valid) begin
              wr_strobe <= wr_hit;
              if (wr_hit) wr_addr <= addr;
              addr <= addr + 7'd1;
            end
          end
          READ: begin
            if (rx_valid) begin
              addr    <= addr + 7'd1;
              tx_byte <= rd_data;
              tx_load <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
